uart_hex_sender: RTL and testbench

- Client-side block on the user end of the UART controller's FIFO interface.
- Converts a DATA_W-bit value into uppercase ASCII hex characters, optionally followed by CR LF, and pushes them into the TX FIFO while honouring tx_full.
- Also drains the RX FIFO. An 'S' or 's' byte triggers a send of the current i_data; any other byte is discarded.
- Sits between application logic (counters, sensors, debug values) and uart_controller.

---
 rtl/uart_hex_sender_if.sv | 20 ++
 rtl/uart_hex_sender.sv | 98 +++++++++
 tb/tb_uart_hex_sender.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_sender_if.sv
// FIFO-side bundle between uart_hex_sender and the UART controller's TX/RX FIFOs.
// master = hex sender, slave = FIFO owner.
interface uart_hex_sender_if;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_push_data;
  logic       rx_empty;
  logic       rx_pop;
  logic [7:0] rx_pop_data;

  modport master (
    input  tx_full, rx_empty, rx_pop_data,
    output tx_push, tx_push_data, rx_pop
  );

  modport slave (
    output tx_full, rx_empty, rx_pop_data,
    input  tx_push, tx_push_data, rx_pop
  );
endinterface

// File: rtl/uart_hex_sender.sv
// Prints a DATA_W-bit value as uppercase ASCII hex (optionally + CR LF) into the UART TX FIFO,
// triggered by i_start or by an 'S'/'s' byte drained from the RX FIFO.
module uart_hex_sender #(
  parameter int unsigned DATA_W    = 16,
  parameter bit          SEND_CRLF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_done,
  uart_hex_sender_if.master fifo
);

  localparam int unsigned NIB   = DATA_W / 4;
  localparam int unsigned N     = NIB + (SEND_CRLF ? 2 : 0);
  localparam int unsigned IDX_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tx_push_c;
  logic                rx_pop_c;
  logic                done_c;
  logic [3:0]          nib_c;
  logic [7:0]          char_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
    end
  end

  // i_start has priority over the RX command path; RX is only drained in IDLE
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    tx_push_c = 1'b0;
    rx_pop_c  = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          shadow_d = i_data;
          idx_d    = '0;
          state_d  = SEND;
        end else if (!fifo.rx_empty) begin
          rx_pop_c = 1'b1;
          if (fifo.rx_pop_data == 8'h53 || fifo.rx_pop_data == 8'h73) begin
            shadow_d = i_data;
            idx_d    = '0;
            state_d  = SEND;
          end
        end
      end
      SEND: begin
        if (!fifo.tx_full) begin
          tx_push_c = 1'b1;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(N - 1)) state_d = DONE;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Character at idx: hex digits MSB nibble first, then CR, LF
  always_comb begin
    nib_c = 4'h0;
    for (int unsigned k = 0; k < NIB; k++) begin
      if (32'(idx_q) == k) nib_c = shadow_q[DATA_W-1-4*k -: 4];
    end
    if (32'(idx_q) < NIB)       char_c = (nib_c < 4'd10) ? 8'h30 + 8'(nib_c) : 8'h37 + 8'(nib_c);
    else if (32'(idx_q) == NIB) char_c = 8'h0D;
    else                        char_c = 8'h0A;
  end

  assign o_busy            = (state_q != IDLE);
  assign o_done            = done_c;
  assign fifo.tx_push      = tx_push_c;
  assign fifo.tx_push_data = char_c;
  assign fifo.rx_pop       = rx_pop_c;

endmodule

// File: tb/tb_uart_hex_sender.sv
// Scoreboard bench: stimulus queues expected output events (with cycle stamps), a negedge
// monitor pops and compares every busy edge, rx_pop, tx_push and o_done of two DUT instances.
module tb_uart_hex_sender;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_POP  = 2;
  localparam int K_PUSH = 3;
  localparam int K_DONE = 4;

  typedef struct {
    int kind;
    int data;
    int cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        start0, start1;
  logic [15:0] data0, data1;
  logic        busy0, busy1, done0, done1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          init_done = 1'b0;
  bit          end_req = 1'b0;
  bit          end_done = 1'b0;
  bit          prev_busy0 = 1'b0;
  bit          prev_busy1 = 1'b0;
  ev_t         q0[$];
  ev_t         q1[$];

  uart_hex_sender_if f0();
  uart_hex_sender_if f1();

  uart_hex_sender #(.DATA_W(16), .SEND_CRLF(1'b1)) dut0 (
    .clk(clk), .rst(rst0), .i_start(start0), .i_data(data0),
    .o_busy(busy0), .o_done(done0), .fifo(f0)
  );

  uart_hex_sender #(.DATA_W(16), .SEND_CRLF(1'b0)) dut1 (
    .clk(clk), .rst(rst1), .i_start(start1), .i_data(data1),
    .o_busy(busy1), .o_done(done1), .fifo(f1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "busy_rise";
      K_FALL:  return "busy_fall";
      K_POP:   return "rx_pop";
      K_PUSH:  return "tx_push";
      default: return "done";
    endcase
  endfunction

  // ---------------- monitor side ----------------
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_ev(input int d, input int k, input int v);
    ev_t e;
    bit  have;
    have = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL dut%0d unexpected %s: got data %02h at cycle %0d, required no event", d, kname(k), v, cyc);
    end else if (e.kind != k || e.data != v || e.cyc != cyc) begin
      errors++;
      $display("FAIL dut%0d %s: got %s data %02h cycle %0d, required %s data %02h cycle %0d",
               d, kname(e.kind), kname(k), v, cyc, kname(e.kind), e.data, e.cyc);
    end
  endtask

  task automatic mon_dut(input int d, input bit busy, input bit done, input bit push,
                         input logic [7:0] pdata, input bit pop);
    bit pb;
    pb = (d == 0) ? prev_busy0 : prev_busy1;
    if (busy != pb) check_ev(d, busy ? K_RISE : K_FALL, 0);
    if (d == 0) prev_busy0 = busy; else prev_busy1 = busy;
    if (pop)  check_ev(d, K_POP, 0);
    if (push) check_ev(d, K_PUSH, int'(pdata));
    if (done) check_ev(d, K_DONE, 0);
    if (push && pop) begin
      checks++;
      errors++;
      $display("FAIL dut%0d exclusive: got tx_push=1 rx_pop=1 at cycle %0d, required at most one", d, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!init_done) begin
        cmp("reset busy0", int'(busy0), 0);
        cmp("reset done0", int'(done0), 0);
        cmp("reset push0", int'(f0.tx_push), 0);
        cmp("reset pop0",  int'(f0.rx_pop), 0);
        cmp("reset busy1", int'(busy1), 0);
        cmp("reset push1", int'(f1.tx_push), 0);
        init_done = 1'b1;
      end else begin
        mon_dut(0, busy0, done0, f0.tx_push, f0.tx_push_data, f0.rx_pop);
        mon_dut(1, busy1, done1, f1.tx_push, f1.tx_push_data, f1.rx_pop);
      end
      if (end_req && !end_done) begin
        cmp("leftover events dut0", q0.size(), 0);
        cmp("leftover events dut1", q1.size(), 0);
        end_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus side ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int d, input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.data = v;
    e.cyc  = c;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic drv_start(input int d, input bit v);
    if (d == 0) start0 = v; else start1 = v;
  endtask

  task automatic drv_data(input int d, input logic [15:0] v);
    if (d == 0) data0 = v; else data1 = v;
  endtask

  task automatic drv_rx(input int d, input bit empty, input logic [7:0] b);
    if (d == 0) begin f0.rx_empty = empty; f0.rx_pop_data = b; end
    else        begin f1.rx_empty = empty; f1.rx_pop_data = b; end
  endtask

  task automatic drv_full(input int d, input bit v);
    if (d == 0) f0.tx_full = v; else f1.tx_full = v;
  endtask

  // Queue the events of one message triggered in cycle t; endc is the next IDLE cycle
  task automatic expect_msg(input int d, input int t, input logic [47:0] chars, input int n,
                            input int stall_idx, input int stall_len, output int endc);
    int c;
    c = t + 1;
    push_ev(d, K_RISE, 0, t + 1);
    for (int i = 0; i < n; i++) begin
      if (i == stall_idx) c += stall_len;
      push_ev(d, K_PUSH, int'(chars[47-8*i -: 8]), c);
      c++;
    end
    push_ev(d, K_DONE, 0, c);
    push_ev(d, K_FALL, 0, c + 1);
    endc = c + 1;
  endtask

  task automatic do_msg(input int d, input logic [15:0] data, input logic [47:0] chars, input int n,
                        input bit use_rx, input logic [7:0] rxb, input bit hold_rx,
                        input int stall_idx, input int stall_len);
    int t, endc, s0;
    t = cyc;
    drv_data(d, data);
    if (use_rx) begin
      drv_rx(d, 1'b0, rxb);
      push_ev(d, K_POP, 0, t);
    end else begin
      drv_start(d, 1'b1);
      if (hold_rx) drv_rx(d, 1'b0, 8'h53);
    end
    expect_msg(d, t, chars, n, stall_idx, stall_len, endc);
    s0 = t + 1 + stall_idx;
    tick();
    drv_start(d, 1'b0);
    drv_data(d, ~data);
    if (!hold_rx) drv_rx(d, 1'b1, 8'h00);
    while (cyc < endc) begin
      drv_full(d, stall_idx >= 0 && cyc >= s0 && cyc < s0 + stall_len);
      drv_start(d, cyc == t + 3);
      tick();
    end
    drv_full(d, 1'b0);
    drv_start(d, 1'b0);
  endtask

  initial begin
    int t;
    rst0 = 1'b1; rst1 = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    data0 = 16'h0; data1 = 16'h0;
    f0.tx_full = 1'b0; f0.rx_empty = 1'b1; f0.rx_pop_data = 8'h00;
    f1.tx_full = 1'b0; f1.rx_empty = 1'b1; f1.rx_pop_data = 8'h00;
    repeat (3) tick();
    rst0 = 1'b0; rst1 = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();

    // basic send, then back-to-back with 4-cycle stall on the 3rd char
    do_msg(0, 16'h1A2F, 48'h31_41_32_46_0D_0A, 6, 1'b0, 8'h00, 1'b0, -1, 0);
    do_msg(0, 16'h1A2F, 48'h31_41_32_46_0D_0A, 6, 1'b0, 8'h00, 1'b0, 2, 4);
    tick();
    // RX 'S' command
    do_msg(0, 16'hBEEF, 48'h42_45_45_46_0D_0A, 6, 1'b1, 8'h53, 1'b0, -1, 0);
    tick();
    // RX discard of 'x'
    t = cyc;
    drv_rx(0, 1'b0, 8'h78);
    push_ev(0, K_POP, 0, t);
    tick();
    drv_rx(0, 1'b1, 8'h00);
    repeat (2) tick();
    // i_start beats a pending 'S'; the byte stays and triggers the next message
    do_msg(0, 16'h09AF, 48'h30_39_41_46_0D_0A, 6, 1'b0, 8'h00, 1'b1, -1, 0);
    do_msg(0, 16'h0000, 48'h30_30_30_30_0D_0A, 6, 1'b1, 8'h53, 1'b0, -1, 0);
    tick();
    // lowercase 's' with a stall on the final LF
    do_msg(0, 16'h09AF, 48'h30_39_41_46_0D_0A, 6, 1'b1, 8'h73, 1'b0, 5, 1);
    tick();
    // reset after 2nd push: abandoned, no done
    t = cyc;
    drv_data(0, 16'h1A2F);
    drv_start(0, 1'b1);
    push_ev(0, K_RISE, 0, t + 1);
    push_ev(0, K_PUSH, 32'h31, t + 1);
    push_ev(0, K_PUSH, 32'h41, t + 2);
    push_ev(0, K_FALL, 0, t + 3);
    tick();
    drv_start(0, 1'b0);
    tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    repeat (2) tick();
    do_msg(0, 16'h1A2F, 48'h31_41_32_46_0D_0A, 6, 1'b0, 8'h00, 1'b0, -1, 0);
    tick();

    // no CR LF variant
    do_msg(1, 16'hF000, 48'h46_30_30_30_00_00, 4, 1'b0, 8'h00, 1'b0, -1, 0);
    do_msg(1, 16'hC5D7, 48'h43_35_44_37_00_00, 4, 1'b1, 8'h73, 1'b0, 0, 2);
    repeat (3) tick();

    end_req = 1'b1;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
